eon_spi_target: RTL and testbench

EON_SPI_TARGET -- requirements
Module: eon_spi_target

---
 rtl/eon_spi_target.sv | 184 ++++++++++++++++++
 tb/tb_eon_spi_target.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/eon_spi_target.sv
// SPI mode-0 target with byte-wide TX/RX handshakes and a sticky RX overrun flag.
// Define EON_SPI_TARGET_RXFIFO_EN to replace the single RX holding register with a 4-entry FIFO.
module eon_spi_target #(
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ssn,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  ssn_sync, sck_sync;
  logic [1:0]  mosi_sync;
  logic        ssn_fall, ssn_rise, sck_rise, sck_fall, mosi_s;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_shift, tx_shift, tx_hold, done_byte;
  logic        tx_full, byte_end, done;
  logic        tx_accept, tx_consume;
  logic        rx_deq, overrun_set, overrun_q;

  // Two flops synchronise; the third holds the previous synced value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ssn_sync  <= 3'b111;
      sck_sync  <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      ssn_sync  <= {ssn_sync[1:0], ssn};
      sck_sync  <= {sck_sync[1:0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign ssn_fall = ssn_sync[2] & ~ssn_sync[1];
  assign ssn_rise = ~ssn_sync[2] & ssn_sync[1];
  assign sck_rise = ~sck_sync[2] & sck_sync[1];
  assign sck_fall = sck_sync[2] & ~sck_sync[1];
  assign mosi_s   = mosi_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaulting state_d first keeps this block free of inferred latches.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ssn_fall) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (sck_fall && byte_end) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (ssn_rise) state_d = IDLE;
  end

  assign tx_ready   = ~tx_full;
  assign tx_accept  = tx_valid & ~tx_full;
  assign tx_consume = (state_q == LOAD) & ~ssn_rise & tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 8'h00;
      tx_hold   <= 8'h00;
      tx_full   <= 1'b0;
      byte_end  <= 1'b0;
      done      <= 1'b0;
      done_byte <= 8'h00;
    end else begin
      done    <= 1'b0;
      tx_full <= tx_accept | (tx_full & ~tx_consume);
      if (tx_accept) tx_hold <= tx_data;

      if (ssn_rise) begin
        // Deselect drops partial RX bits and the in-flight TX byte; the holding register survives.
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
        tx_shift <= 8'h00;
        byte_end <= 1'b0;
      end else begin
        unique case (state_q)
          LOAD: begin
            tx_shift <= tx_full ? tx_hold : FILL_BYTE;
            byte_end <= 1'b0;
          end
          SHIFT: begin
            if (sck_rise) begin
              rx_shift <= {rx_shift[6:0], mosi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                done      <= 1'b1;
                done_byte <= {rx_shift[6:0], mosi_s};
                byte_end  <= 1'b1;
              end
            end else if (sck_fall) begin
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef EON_SPI_TARGET_RXFIFO_EN
  logic [7:0] rx_mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] rx_count;
  logic       rx_wr;

  assign rx_valid    = (rx_count != 3'd0);
  assign rx_deq      = rx_valid & rx_ready;
  assign overrun_set = done & (rx_count == 3'd4) & ~rx_deq;
  assign rx_wr       = done & ~overrun_set;
  assign rx_data     = rx_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the FIFO storage is reset so rx_data reads 0 out of reset.
      for (int i = 0; i < 4; i++) rx_mem[i] <= 8'h00;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      rx_count <= 3'd0;
    end else begin
      if (rx_wr) begin
        rx_mem[wr_ptr] <= done_byte;
        wr_ptr         <= wr_ptr + 2'd1;
      end
      if (rx_deq) rd_ptr <= rd_ptr + 2'd1;
      rx_count <= rx_count + {2'b00, rx_wr} - {2'b00, rx_deq};
    end
  end
`else
  logic [7:0] rx_data_q;
  logic       rx_valid_q;

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_deq      = rx_valid_q & rx_ready;
  assign overrun_set = done & rx_valid_q & ~rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else if (done && !overrun_set) begin
      rx_data_q  <= done_byte;
      rx_valid_q <= 1'b1;
    end else if (rx_deq) begin
      rx_valid_q <= 1'b0;
    end
  end
`endif

  // A new overrun wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_set | (overrun_q & ~overrun_clr);
  end

  assign overrun = overrun_q;
  assign miso_oe = ~ssn_sync[1];
  assign miso    = miso_oe & tx_shift[7];
  assign busy    = (state_q != IDLE) | (bit_cnt != 3'd0);

endmodule

// File: tb/tb_eon_spi_target.sv
// Directed bench for eon_spi_target: drives an SPI mode-0 controller at clk/8 and checks
// handshakes, fill byte, overrun, mid-byte deselect and mid-byte reset.
module tb_eon_spi_target;

  logic       clk = 1'b0;
  logic       rst, ssn, sck, mosi, miso, miso_oe;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic       overrun, overrun_clr, busy;
  logic [7:0] mi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  eon_spi_target #(.FILL_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .ssn(ssn), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic queue_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic select_target();
    @(negedge clk);
    ssn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic deselect_target();
    repeat (4) @(negedge clk);
    ssn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Clocks nbits of mo, MSB first; mi captures miso just before each rise.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit chk_lat,
                          output logic [7:0] mi_out);
    mi_out = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = mo[i];
      repeat ((i == 7) ? 6 : 4) @(negedge clk);
      mi_out[i] = miso;
      sck = 1'b1;
      if (chk_lat && i == 0) begin
        repeat (3) @(posedge clk);
        #1 check("rx_valid_early", rx_valid, 1'b0);
        @(posedge clk);
        #1 check("rx_valid_latency", rx_valid, 1'b1);
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      sck = 1'b0;
    end
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check({tag, "_valid"}, rx_valid, 1'b1);
    check({tag, "_data"}, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_ready"}, tx_ready, 1'b1);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_rx_data"}, rx_data, 8'h00);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_miso"}, miso, 1'b0);
    check({tag, "_miso_oe"}, miso_oe, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ssn = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Queued TX byte goes out while the controller sends 3C.
    queue_tx(8'hA5);
    check("tx_ready_full", tx_ready, 1'b0);
    select_target();
    repeat (4) @(negedge clk);
    check("miso_oe_sel", miso_oe, 1'b1);
    check("tx_ready_load", tx_ready, 1'b1);
    check("busy_sel", busy, 1'b1);
    spi_bits(8'h3C, 8, 1'b1, mi);
    check("miso_a5", mi, 8'hA5);
    deselect_target();
    pop("rx_3c", 8'h3C);
    @(negedge clk);
    check("rx_empty_after_pop", rx_valid, 1'b0);

    // Nothing queued: fill byte on both bytes, two RX bytes in order.
    select_target();
    spi_bits(8'h5A, 8, 1'b0, mi);
    check("fill_b0", mi, 8'hFF);
    pop("rx_5a", 8'h5A);
    spi_bits(8'hC3, 8, 1'b0, mi);
    check("fill_b1", mi, 8'hFF);
    deselect_target();
    pop("rx_c3", 8'hC3);

`ifdef EON_SPI_TARGET_RXFIFO_EN
    // Five bytes into a 4-deep FIFO without draining.
    select_target();
    for (int b = 1; b <= 5; b++) spi_bits(8'(b), 8, 1'b0, mi);
    deselect_target();
    check("ovr_set", overrun, 1'b1);
    for (int b = 1; b <= 4; b++) pop("fifo", 8'(b));
    @(negedge clk);
    check("fifo_drained", rx_valid, 1'b0);
`else
    // Two bytes into the single holding register without draining.
    select_target();
    spi_bits(8'h11, 8, 1'b0, mi);
    spi_bits(8'h22, 8, 1'b0, mi);
    deselect_target();
    check("ovr_set", overrun, 1'b1);
    check("ovr_kept_first", rx_data, 8'h11);
    pop("ovr_pop", 8'h11);
    @(negedge clk);
    check("ovr_drained", rx_valid, 1'b0);
`endif
    check("ovr_sticky", overrun, 1'b1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    @(negedge clk);
    check("ovr_cleared", overrun, 1'b0);

    // Deselect after 5 bits discards the partial byte.
    select_target();
    spi_bits(8'hF0, 5, 1'b0, mi);
    repeat (2) @(negedge clk);
    check("busy_mid", busy, 1'b1);
    deselect_target();
    check("abort_rx_valid", rx_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_miso_oe", miso_oe, 1'b0);
    check("abort_miso", miso, 1'b0);
    select_target();
    spi_bits(8'h96, 8, 1'b0, mi);
    deselect_target();
    check("after_abort_valid", rx_valid, 1'b1);
    check("after_abort_data", rx_data, 8'h96);

    // Reset mid-byte with a TX byte queued and an RX byte pending.
    queue_tx(8'h77);
    select_target();
    spi_bits(8'hE0, 3, 1'b0, mi);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    ssn = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_tx_ready", tx_ready, 1'b1);
    queue_tx(8'h81);
    select_target();
    spi_bits(8'h42, 8, 1'b0, mi);
    check("post_rst_miso", mi, 8'h81);
    deselect_target();
    pop("post_rst_rx", 8'h42);
    check("post_rst_overrun", overrun, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
